// File: rtl/debug_capture_ctrl_pkg.sv
// debug_capture_ctrl_pkg: shared widths and FSM state encodings for the debug capture block
package debug_capture_ctrl_pkg;
    localparam int DBG_FRAME_W = 9;
    localparam int DBG_REG_W   = 4;
    localparam int DBG_DEPTH   = 8;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_READOUT = 3'd3
    } state_t;
endpackage

// File: rtl/dbg_capture_buf.sv
// dbg_capture_buf: capture storage, one sync write port and one registered read port
module dbg_capture_buf #(
    parameter int ENTRY_W = 13,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // only the read register is reset so the readout outputs start at zero
    always_ff @(posedge clk) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/debug_capture_ctrl.sv
// debug_capture_ctrl: trigger-armed snapshot of received frames, played back over valid/ready
module debug_capture_ctrl
    import debug_capture_ctrl_pkg::*;
#(
    parameter int FRAME_W = DBG_FRAME_W,
    parameter int REG_W   = DBG_REG_W,
    parameter int DEPTH   = DBG_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               debug,
    input  logic               arm,
    input  logic               stop,
    input  logic [FRAME_W-1:0] trig_val,
    input  logic [FRAME_W-1:0] trig_mask,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    input  logic [REG_W-1:0]   data_out,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FRAME_W-1:0] rd_frame,
    output logic [REG_W-1:0]   rd_reg,
    output logic [CNT_W-2:0]   rd_index,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               done
);
    localparam int ENTRY_W = FRAME_W + REG_W;
    localparam int PW      = CNT_W - 1;
    state_t             st, st_nx;
    logic [CNT_W-1:0]   count_nx;
    logic [PW-1:0]      rd_index_nx, waddr, raddr, last;
    logic               rd_valid_nx, overflow_nx, done_nx, we, re, hit;
    logic [ENTRY_W-1:0] rdata;
    assign state    = st;
    assign hit      = frame_valid && (((frame ^ trig_val) & trig_mask) == '0);
    assign last     = PW'(count - 1'b1);
    assign rd_frame = rdata[ENTRY_W-1:REG_W];
    assign rd_reg   = rdata[REG_W-1:0];
    always_comb begin
        st_nx       = st;
        count_nx    = count;
        rd_valid_nx = rd_valid;
        rd_index_nx = rd_index;
        overflow_nx = overflow;
        done_nx     = 1'b0;
        we          = 1'b0;
        re          = 1'b0;
        waddr       = count[PW-1:0];
        raddr       = rd_index;
        if (!debug) begin
            st_nx       = S_IDLE;
            count_nx    = '0;
            rd_valid_nx = 1'b0;
        end else begin
            case (st)
                S_IDLE: if (arm) begin
                    st_nx       = S_ARMED;
                    count_nx    = '0;
                    overflow_nx = 1'b0;
                end
                S_ARMED: if (hit) begin
                    we       = 1'b1;
                    waddr    = '0;
                    count_nx = CNT_W'(1);
                    st_nx    = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (frame_valid) begin
                        we       = 1'b1;
                        count_nx = count + 1'b1;
                    end
                    if (stop || count_nx == CNT_W'(DEPTH)) st_nx = S_READOUT;
                end
                S_READOUT: begin
                    if (frame_valid) overflow_nx = 1'b1;
                    // first READOUT cycle primes entry 0; afterwards each accept loads the next
                    if (!rd_valid) begin
                        re          = 1'b1;
                        raddr       = '0;
                        rd_index_nx = '0;
                        rd_valid_nx = 1'b1;
                    end else if (rd_ready) begin
                        if (rd_index == last) begin
                            rd_valid_nx = 1'b0;
                            done_nx     = 1'b1;
                            st_nx       = S_IDLE;
                        end else begin
                            re          = 1'b1;
                            raddr       = rd_index + 1'b1;
                            rd_index_nx = raddr;
                        end
                    end
                end
                default: st_nx = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            st       <= S_IDLE;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_index <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            st       <= st_nx;
            count    <= count_nx;
            rd_valid <= rd_valid_nx;
            rd_index <= rd_index_nx;
            overflow <= overflow_nx;
            done     <= done_nx;
        end
    end
    dbg_capture_buf #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .AW(PW)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(waddr),
        .wdata({frame, data_out}),
        .re   (re),
        .raddr(raddr),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_debug_capture_ctrl.sv
// tb_debug_capture_ctrl: directed checks of trigger, capture, readout handshake, drops and abort
module tb_debug_capture_ctrl;
    logic       clk = 1'b0;
    logic       rst, debug, arm, stop, frame_valid, rd_ready;
    logic [8:0] trig_val, trig_mask, frame;
    logic [3:0] data_out;
    logic       rd_valid, overflow, done;
    logic [8:0] rd_frame;
    logic [3:0] rd_reg;
    logic [2:0] rd_index, state;
    logic [3:0] count;
    logic [8:0] ef [8];
    int         checks = 0;
    int         failures = 0;
    int         cyc;

    debug_capture_ctrl dut (
        .clk(clk), .rst(rst), .debug(debug), .arm(arm), .stop(stop),
        .trig_val(trig_val), .trig_mask(trig_mask), .frame_valid(frame_valid),
        .frame(frame), .data_out(data_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_frame(rd_frame), .rd_reg(rd_reg), .rd_index(rd_index), .state(state),
        .count(count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] reg_of(input logic [8:0] f);
        return f[3:0] ^ 4'hA;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] f);
        frame_valid = 1'b1;
        frame = f;
        data_out = reg_of(f);
        tick();
        frame_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // drains n entries with rd_ready following pat; every presented cycle is compared
    task automatic readout(input int n, input logic [3:0] pat, output int cycles);
        int got = 0;
        cycles = 0;
        for (int c = 0; c < 40 && got < n; c++) begin
            rd_ready = pat[c % 4];
            if (rd_valid) begin
                check("rd_frame", rd_frame, ef[got]);
                check("rd_reg", rd_reg, reg_of(ef[got]));
                check("rd_index", rd_index, got);
                if (rd_ready) got++;
            end
            tick();
            cycles++;
        end
        rd_ready = 1'b0;
        check("rd_entries", got, n);
        check("rd_valid_end", rd_valid, 0);
        check("done_pulse", done, 1);
        check("state_idle_end", state, 0);
        tick();
        check("done_clear", done, 0);
    endtask

    initial begin
        rst = 1'b0; debug = 1'b1; arm = 1'b0; stop = 1'b0; frame_valid = 1'b0;
        rd_ready = 1'b0; trig_val = '0; trig_mask = '0; frame = '0; data_out = '0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        check("rst_rd_frame", rd_frame, 0);
        rst = 1'b1;

        // trigger on exact match, fill to DEPTH
        trig_mask = 9'h1FF; trig_val = 9'h0A5;
        do_arm();
        check("t1_armed", state, 1);
        send(9'h011);
        check("t1_nomatch_state", state, 1);
        check("t1_nomatch_count", count, 0);
        send(9'h0A5);
        check("t1_trig_count", count, 1);
        check("t1_trig_state", state, 2);
        ef[0] = 9'h0A5;
        for (int i = 0; i < 7; i++) begin
            ef[i+1] = 9'h100 + 9'(i);
            send(9'h100 + 9'(i));
        end
        check("t1_full_count", count, 8);
        check("t1_full_state", state, 3);
        check("t1_first_gap", rd_valid, 0);
        readout(8, 4'b1111, cyc);
        check("t1_cycles", cyc, 9);

        // early stop, then stop with a frame in the same cycle
        trig_mask = '0;
        do_arm();
        send(9'h001);
        send(9'h002);
        check("t2_count", count, 2);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t2_stop_state", state, 3);
        check("t2_stop_count", count, 2);
        ef[0] = 9'h001; ef[1] = 9'h002;
        readout(2, 4'b1111, cyc);
        do_arm();
        send(9'h003);
        stop = 1'b1;
        send(9'h004);
        check("t2_sf_count", count, 2);
        check("t2_sf_state", state, 3);
        ef[0] = 9'h003; ef[1] = 9'h004;
        readout(2, 4'b1111, cyc);

        // back-pressure with ready 1,0,0,1
        do_arm();
        send(9'h010); send(9'h011); send(9'h012);
        stop = 1'b1; tick(); stop = 1'b0;
        ef[0] = 9'h010; ef[1] = 9'h011; ef[2] = 9'h012;
        readout(3, 4'b1001, cyc);

        // drop during readout sets sticky overflow
        do_arm();
        send(9'h020); send(9'h021);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_pre_ovf", overflow, 0);
        send(9'h1FF);
        check("t4_ovf", overflow, 1);
        check("t4_count", count, 2);
        ef[0] = 9'h020; ef[1] = 9'h021;
        readout(2, 4'b1111, cyc);
        check("t4_ovf_after_done", overflow, 1);
        do_arm();
        check("t4_ovf_cleared", overflow, 0);
        check("t4_armed", state, 1);

        // abort by debug low, arm ignored while debug low, reset in readout
        send(9'h030); send(9'h031); send(9'h032);
        check("t5_count3", count, 3);
        debug = 1'b0; tick();
        check("t5_abort_state", state, 0);
        check("t5_abort_count", count, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t5_arm_ignored", state, 0);
        debug = 1'b1;
        do_arm();
        send(9'h040); send(9'h041);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        check("t5_rd_valid", rd_valid, 1);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check("t5_rd_index", rd_index, 1);
        check("t5_rd_frame", rd_frame, 9'h041);
        rst = 1'b0; tick(); rst = 1'b1;
        check("t5_rst_state", state, 0);
        check("t5_rst_rd_valid", rd_valid, 0);
        check("t5_rst_rd_frame", rd_frame, 0);
        check("t5_rst_rd_reg", rd_reg, 0);
        check("t5_rst_rd_index", rd_index, 0);
        check("t5_rst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
